// File: rtl/kb_div_pkg.sv
// Shared types and default sizing for the constant-divisor serial divider.
package kb_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int unsigned DefDataWidth = 20;
  localparam int unsigned DefDivisor   = 3;

endpackage

// File: rtl/kb_divk_step.sv
// One restoring-division step: shift a dividend bit into the partial remainder,
// subtract the constant divisor when it fits, and emit the quotient bit.
module kb_divk_step #(
  parameter int unsigned DIVISOR   = 3,
  parameter int unsigned REM_WIDTH = 2
) (
  input  logic [REM_WIDTH:0] rem_i,
  input  logic               bit_i,
  output logic [REM_WIDTH:0] rem_o,
  output logic               q_o
);

  localparam logic [REM_WIDTH+1:0] DivW = (REM_WIDTH + 2)'(DIVISOR);

  logic [REM_WIDTH+1:0] r_shift;
  logic [REM_WIDTH+1:0] r_sel;
  // The remainder stays below DIVISOR, so the selected value never needs its top bit.
  logic                 unused_sel_msb;

  // Compare-and-subtract on the widened shifted remainder.
  always_comb begin
    r_shift = {rem_i, bit_i};
    q_o     = (r_shift >= DivW);
    r_sel   = q_o ? (r_shift - DivW) : r_shift;
    rem_o   = r_sel[REM_WIDTH:0];
  end

  assign unused_sel_msb = r_sel[REM_WIDTH+1];

endmodule

// File: rtl/kb_divk_serial.sv
// Serial unsigned divider by a constant: one restoring step per cycle,
// DATA_WIDTH cycles per operation, valid/ready handshakes on both sides.
module kb_divk_serial
  import kb_div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned DIVISOR    = DefDivisor,
  localparam int unsigned REM_WIDTH = $clog2(DIVISOR)
) (
  input  logic                  sys_clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [REM_WIDTH-1:0]  remainder,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  if (DIVISOR < 2 || 64'(DIVISOR) >= (64'd1 << DATA_WIDTH)) begin : gen_bad_divisor
    $error("kb_divk_serial: DIVISOR must satisfy 2 <= DIVISOR < 2**DATA_WIDTH");
  end

  div_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [REM_WIDTH:0]    rem_q, rem_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  in_ready_q, out_valid_q, busy_q;

  logic [REM_WIDTH:0]    step_rem;
  logic                  step_q;

  kb_divk_step #(
    .DIVISOR   (DIVISOR),
    .REM_WIDTH (REM_WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .bit_i (shift_q[DATA_WIDTH-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Next-state: the shift register doubles as the quotient accumulator, dividend
  // bits leave at the MSB while quotient bits enter at the LSB.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = BUSY;
          shift_d = dividend;
          rem_d   = '0;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        shift_d = {shift_q[DATA_WIDTH-2:0], step_q};
        rem_d   = step_rem;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready && out_valid_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered handshake flags; reset discards any operation in flight.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d == BUSY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign quotient  = shift_q;
  assign remainder = rem_q[REM_WIDTH-1:0];

endmodule

// File: tb/tb_kb_divk_serial.sv
// Directed bench: default 20-bit /3 instance plus an 8-bit /5 instance.
module tb_kb_divk_serial;

  logic        sys_clock = 1'b0;
  logic        reset;

  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  logic [19:0] dividend_a, quotient_a;
  logic [1:0]  remainder_a;

  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [7:0]  dividend_b, quotient_b;
  logic [2:0]  remainder_b;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 sys_clock = ~sys_clock;

  kb_divk_serial u_dut_a (
    .sys_clock (sys_clock),
    .reset     (reset),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .dividend  (dividend_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready_a),
    .quotient  (quotient_a),
    .remainder (remainder_a),
    .busy      (busy_a)
  );

  kb_divk_serial #(
    .DATA_WIDTH (8),
    .DIVISOR    (5)
  ) u_dut_b (
    .sys_clock (sys_clock),
    .reset     (reset),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .dividend  (dividend_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .quotient  (quotient_b),
    .remainder (remainder_b),
    .busy      (busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full transaction on the selected instance: accept, wait with a cycle
  // budget, check latency/result, optionally backpressure, then hand off.
  task automatic run(input bit sel_b, input logic [31:0] d, input logic [31:0] exp_q,
                     input logic [31:0] exp_r, input int hold, input bit mess,
                     input string tag);
    int cyc;
    int exp_lat;
    exp_lat = sel_b ? 8 : 20;
    if (sel_b) begin
      in_valid_b = 1'b1;
      dividend_b = d[7:0];
    end else begin
      in_valid_a = 1'b1;
      dividend_a = d[19:0];
    end
    check({tag, " in_ready"}, sel_b ? in_ready_b : in_ready_a, 1);
    @(posedge sys_clock); #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    check({tag, " busy"}, sel_b ? busy_b : busy_a, 1);
    cyc = 0;
    while (cyc < 64) begin
      if (mess) begin
        if (sel_b) begin
          in_valid_b = 1'($urandom_range(0, 1));
          dividend_b = 8'($urandom);
        end else begin
          in_valid_a = 1'($urandom_range(0, 1));
          dividend_a = 20'($urandom);
        end
      end
      @(posedge sys_clock); #1;
      cyc++;
      if (sel_b ? out_valid_b : out_valid_a) break;
    end
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " quotient"}, sel_b ? 32'(quotient_b) : 32'(quotient_a), exp_q);
    check({tag, " remainder"}, sel_b ? 32'(remainder_b) : 32'(remainder_a), exp_r);
    for (int i = 0; i < hold; i++) begin
      @(posedge sys_clock); #1;
      check({tag, " hold out_valid"}, sel_b ? out_valid_b : out_valid_a, 1);
      check({tag, " hold in_ready"}, sel_b ? in_ready_b : in_ready_a, 0);
      check({tag, " hold quotient"}, sel_b ? 32'(quotient_b) : 32'(quotient_a), exp_q);
      check({tag, " hold remainder"}, sel_b ? 32'(remainder_b) : 32'(remainder_a), exp_r);
    end
    if (sel_b) out_ready_b = 1'b1;
    else out_ready_a = 1'b1;
    @(posedge sys_clock); #1;
    out_ready_a = 1'b0;
    out_ready_b = 1'b0;
    check({tag, " out_valid drop"}, sel_b ? out_valid_b : out_valid_a, 0);
    check({tag, " in_ready back"}, sel_b ? in_ready_b : in_ready_a, 1);
  endtask

  initial begin
    logic [31:0] rd;
    bit          saw_valid;
    reset       = 1'b1;
    in_valid_a  = 1'b0;
    out_ready_a = 1'b0;
    dividend_a  = '0;
    in_valid_b  = 1'b0;
    out_ready_b = 1'b0;
    dividend_b  = '0;
    repeat (2) @(posedge sys_clock);
    #1 reset = 1'b0;
    #1;
    check("reset in_ready", in_ready_a, 1);
    check("reset out_valid", out_valid_a, 0);
    check("reset busy", busy_a, 0);
    check("reset quotient", quotient_a, 0);
    check("reset remainder", remainder_a, 0);
    @(posedge sys_clock); #1;

    run(1'b0, 32'd7, 32'd2, 32'd1, 0, 1'b0, "a_7");
    run(1'b0, 32'hFFFFF, 32'd349525, 32'd0, 0, 1'b0, "a_fffff");
    run(1'b0, 32'hFFFFE, 32'd349524, 32'd2, 0, 1'b0, "a_ffffe");
    run(1'b0, 32'd0, 32'd0, 32'd0, 0, 1'b0, "a_zero");
    run(1'b0, 32'd100, 32'd33, 32'd1, 10, 1'b0, "a_backpressure");
    run(1'b0, 32'd12345, 32'd4115, 32'd0, 0, 1'b1, "a_toggle_busy");

    // Abort at iteration 10: outputs clear immediately and no result appears.
    in_valid_a = 1'b1;
    dividend_a = 20'd1000;
    @(posedge sys_clock); #1;
    in_valid_a = 1'b0;
    repeat (10) @(posedge sys_clock);
    #1 reset = 1'b1;
    #1;
    check("abort quotient", quotient_a, 0);
    check("abort remainder", remainder_a, 0);
    check("abort busy", busy_a, 0);
    check("abort out_valid", out_valid_a, 0);
    @(posedge sys_clock); #1;
    reset = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge sys_clock); #1;
      if (out_valid_a) saw_valid = 1'b1;
    end
    check("abort no out_valid", saw_valid, 0);
    check("abort in_ready", in_ready_a, 1);
    run(1'b0, 32'd9, 32'd3, 32'd0, 0, 1'b0, "a_after_abort");

    run(1'b1, 32'd255, 32'd51, 32'd0, 0, 1'b0, "b_255");
    run(1'b1, 32'd254, 32'd50, 32'd4, 0, 1'b0, "b_254");
    for (int i = 0; i < 64; i++) begin
      rd = $urandom_range(0, 255);
      run(1'b1, rd, rd / 5, rd % 5, 0, 1'b0, "b_rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
